// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache between fetch unit and instruction memory.
// Latency: hit -> inst_valid_o rises two cycles after inst_req_i is first sampled; a miss adds
//   LINE_WORDS memory handshakes (each >= 2 cycles) plus one re-lookup cycle.
// Backpressure: four-phase req/valid on both sides. mem_req_o/mem_addr_o hold through any number of
//   memory wait states. A new fetch is accepted only back in S_IDLE; transactions never overlap.
// Ports: clk_i, rst_i (sync, active high); fetch side inst_req_i/inst_addr_i -> inst_valid_o/inst_data_o;
//   memory side mem_req_o/mem_addr_o -> mem_valid_i/mem_data_i. All outputs come straight from flops.
module icache #(
  parameter int DATA_WIDTH = 32,
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  inst_req_i,
  input  logic [DATA_WIDTH-1:0] inst_addr_i,
  output logic                  inst_valid_o,
  output logic [DATA_WIDTH-1:0] inst_data_o,
  output logic                  mem_req_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = DATA_WIDTH - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL_REQ,
    S_REFILL_ACK,
    S_RESPOND
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] req_addr_q;
  logic [OFF_W-1:0]      cnt_q;
  logic [OFF_W-1:0]      cnt_d;
  logic [LINES-1:0]      valid_q;
  logic                  inst_valid_q;
  logic [DATA_WIDTH-1:0] inst_data_q;
  logic                  mem_req_q;
  logic [DATA_WIDTH-1:0] mem_addr_q;

  // Tag and data storage carry no reset; the valid bits alone gate their use.
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES*LINE_WORDS];

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit;
  logic             fill_wr;
  logic             line_done;

  assign req_off = req_addr_q[OFF_W-1:0];
  assign req_idx = req_addr_q[OFF_W +: IDX_W];
  assign req_tag = req_addr_q[DATA_WIDTH-1 -: TAG_W];
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign cnt_d   = cnt_q + 1'b1;

  // Word capture happens on the edge where mem_valid_i is first seen in S_REFILL_REQ;
  // the tag is only written once the last word's handshake has fully closed.
  assign fill_wr   = !rst_i && (state_q == S_REFILL_REQ) && mem_valid_i;
  assign line_done = !rst_i && (state_q == S_REFILL_ACK) && !mem_valid_i && (cnt_q == LAST_CNT);

  always_ff @(posedge clk_i) begin
    if (fill_wr) data_q[{req_idx, cnt_q}] <= mem_data_i;
    if (line_done) tag_q[req_idx] <= req_tag;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      req_addr_q   <= '0;
      cnt_q        <= '0;
      valid_q      <= '0;
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (inst_req_i) begin
            req_addr_q <= inst_addr_i;
            state_q    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            inst_data_q <= data_q[{req_idx, req_off}];
            state_q     <= S_RESPOND;
          end else begin
            // Line is invalidated up front so it is never visible half-filled.
            valid_q[req_idx] <= 1'b0;
            cnt_q            <= '0;
            mem_req_q        <= 1'b1;
            mem_addr_q       <= {req_addr_q[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            state_q          <= S_REFILL_REQ;
          end
        end
        S_REFILL_REQ: begin
          if (mem_valid_i) begin
            mem_req_q <= 1'b0;
            state_q   <= S_REFILL_ACK;
          end
        end
        S_REFILL_ACK: begin
          if (!mem_valid_i) begin
            if (cnt_q == LAST_CNT) begin
              valid_q[req_idx] <= 1'b1;
              state_q          <= S_LOOKUP;
            end else begin
              cnt_q      <= cnt_d;
              mem_req_q  <= 1'b1;
              mem_addr_q <= {req_addr_q[DATA_WIDTH-1:OFF_W], cnt_d};
              state_q    <= S_REFILL_REQ;
            end
          end
        end
        S_RESPOND: begin
          // Valid follows the request: it rises on the first RESPOND edge and drops
          // on the edge that sees the request released. A request already dropped
          // early makes this state last one cycle with no response pulse.
          inst_valid_q <= inst_req_i;
          if (!inst_req_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign inst_valid_o = inst_valid_q;
  assign inst_data_o  = inst_data_q;
  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;

endmodule
